// File: rtl/rst_req_gen_pkg.sv
// Shared definitions for the reset-request initiator.
// Contents:
//   state_e   - controller state encoding
//   SyncDepth - number of flops in each input synchronizer
package rst_req_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StRelease,
        StLockout,
        StFault
    } state_e;

    localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/rst_req_gen_if.sv
// Bundle of the reset-request initiator's board and control signals.
// Signals:
//   pb_n         - raw active-low pushbutton (asynchronous)
//   sw_req       - single-cycle software reset request
//   pad_sense    - raw pad level, 1 = released (asynchronous)
//   pad_drive_en - 1 enables the pad's low driver
//   busy         - high whenever the controller is not idle
//   fault        - sticky release-timeout flag
//   req_count    - count of accepted requests (wraps)
// Modports: master drives the inputs and observes the status; slave is the controller.
interface rst_req_gen_if;

    logic       pb_n;
    logic       sw_req;
    logic       pad_sense;
    logic       pad_drive_en;
    logic       busy;
    logic       fault;
    logic [7:0] req_count;

    modport master (
        output pb_n,
        output sw_req,
        output pad_sense,
        input  pad_drive_en,
        input  busy,
        input  fault,
        input  req_count
    );

    modport slave (
        input  pb_n,
        input  sw_req,
        input  pad_sense,
        output pad_drive_en,
        output busy,
        output fault,
        output req_count
    );

endinterface

// File: rtl/rst_req_gen_sync_debounce.sv
// Synchronizer plus debouncer for one asynchronous active-low level input.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - raw asynchronous input (idle high)
//   press_o - registered one-cycle pulse on a debounced high-to-low transition
// The debounced level only moves after DebounceCycles consecutive synchronized samples
// that disagree with it, so a second press needs an accepted release in between.
module rst_req_gen_sync_debounce
    import rst_req_gen_pkg::*;
#(
    parameter int unsigned DebounceCycles = 1000,
    parameter int unsigned CntW           = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic press_o
);

    logic [SyncDepth-1:0] sync_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 sample;

    assign sample = sync_q[SyncDepth-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sample != level_q) begin
            if (cnt_q == CntW'(DebounceCycles - 1)) begin
                level_d = sample;
                press_d = ~sample;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SyncDepth-2:0], d_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/rst_req_gen.sv
// Reset-request initiator for the shared board reset pad.
// Ports:
//   clk     - always-on clock
//   reset_n - asynchronous active-low reset, independent of the pad
//   bus     - slave side of rst_req_gen_if (pushbutton, sw request, pad sense, status)
// A debounced press or a software request drives the pad low for HOLD_CYCLES, then the
// controller waits for the pull-up to restore the pad (flagging a sticky fault after
// RELEASE_TIMEOUT cycles) and enforces LOCKOUT_CYCLES of dead time before re-arming.
module rst_req_gen
    import rst_req_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16'd1000,
    parameter int unsigned HOLD_CYCLES     = 16'd512,
    parameter int unsigned RELEASE_TIMEOUT = 16'd4096,
    parameter int unsigned LOCKOUT_CYCLES  = 16'd2048,
    parameter int unsigned CNT_W           = 16
) (
    input logic          clk,
    input logic          reset_n,
    rst_req_gen_if.slave bus
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           count_q, count_d;
    logic                 drive_q, drive_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;
    logic [SyncDepth-1:0] pad_sync_q;
    logic                 pad_high;
    logic                 press;
    logic                 req;

    rst_req_gen_sync_debounce #(
        .DebounceCycles (DEBOUNCE_CYCLES),
        .CntW           (CNT_W)
    ) u_pb (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .d_i     (bus.pb_n),
        .press_o (press)
    );

    assign pad_high = pad_sync_q[SyncDepth-1];
    // A press and a software request landing together are a single request.
    assign req      = press | bus.sw_req;

    // State, shared counter, request counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            count_q    <= '0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            pad_sync_q <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            pad_sync_q <= {pad_sync_q[SyncDepth-2:0], bus.pad_sense};
        end
    end

    // Next state. The one counter is reloaded with (length - 1) on entry to each timed
    // state and the state ends on the cycle it reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StDrive;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    count_d = count_q + 8'd1;
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    state_d = StRelease;
                    cnt_d   = CNT_W'(RELEASE_TIMEOUT - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRelease: begin
                // Pad release wins over a timeout that expires on the same edge.
                if (pad_high) begin
                    state_d = StLockout;
                    cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StLockout: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StFault: begin
                if (pad_high) begin
                    state_d = StLockout;
                    cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_comb begin
        drive_d = (state_d == StDrive);
        busy_d  = (state_d != StIdle);
        fault_d = fault_q | (state_d == StFault);
    end

    assign bus.pad_drive_en = drive_q;
    assign bus.busy         = busy_q;
    assign bus.fault        = fault_q;
    assign bus.req_count    = count_q;

endmodule

// File: tb/tb_rst_req_gen.sv
module tb_rst_req_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int TMO  = 16;
    localparam int LOCK = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    bit   pad_ok  = 1'b1;  // 1 = healthy pull-up; pad reads high whenever not driven
    int   total   = 0;
    int   bad     = 0;

    rst_req_gen_if bus ();

    rst_req_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .RELEASE_TIMEOUT (TMO),
        .LOCKOUT_CYCLES  (LOCK),
        .CNT_W           (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one request lifetime tracked by absolute edge numbers.
    int       m_k;        // edges since reset release
    bit       m_busy, m_drive, m_fault;
    bit [7:0] m_count;
    int       m_t0;       // edge at which the request was accepted
    int       m_lock;     // edge at which lockout began, -1 before release
    int       m_accepts;
    bit       m_pad_s1, m_pad_s2, m_pb_s1, m_pb_s2;
    bit       m_deb, m_press_pend;
    int       m_run;      // consecutive samples disagreeing with the debounced level

    task automatic model_reset();
        m_k = 0; m_busy = 0; m_drive = 0; m_fault = 0; m_count = 0;
        m_t0 = 0; m_lock = -1;
        m_pad_s1 = 1; m_pad_s2 = 1; m_pb_s1 = 1; m_pb_s2 = 1;
        m_deb = 1; m_press_pend = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit sw, input bit pb, input bit pad);
        bit req;
        bit press;
        m_k++;
        req = sw | m_press_pend;
        if (!m_busy) begin
            if (req) begin
                m_busy = 1; m_t0 = m_k; m_lock = -1; m_count++; m_accepts++;
            end
        end else if (m_lock < 0) begin
            if (m_k > m_t0 + HOLD) begin
                if (m_pad_s2) m_lock = m_k;
                else if (m_k == m_t0 + HOLD + TMO) m_fault = 1;
            end
        end else if (m_k == m_lock + LOCK) begin
            m_busy = 0;
        end
        m_drive = m_busy && (m_lock < 0) && (m_k < m_t0 + HOLD);
        press = 0;
        if (m_pb_s2 != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = m_pb_s2; press = !m_pb_s2; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_press_pend = press;
        m_pad_s2 = m_pad_s1; m_pad_s1 = pad;
        m_pb_s2  = m_pb_s1;  m_pb_s1  = pb;
    endtask

    function automatic logic [10:0] obs_vec();
        return {bus.pad_drive_en, bus.busy, bus.fault, bus.req_count};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {m_drive, m_busy, m_fault, m_count};
    endfunction

    // One clock: the pad follows the expected drive through the pull-up, the model
    // consumes the inputs the DUT samples at this edge, outputs are read 1ns later.
    task automatic step();
        bus.pad_sense = pad_ok & ~m_drive;
        model_edge(bus.sw_req, bus.pb_n, bus.pad_sense);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.sw_req = 1'b0; bus.pb_n = 1'b1; pad_ok = 1'b1;
        reset_n = 1'b0;
        model_reset();
        bus.pad_sense = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs_vec() !== 11'd0) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 11'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_idle k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_sw_req();
        int first_drive = -1;
        int drive_cnt   = 0;
        int busy_fall   = -1;
        do_reset();
        repeat (10) step();
        bus.sw_req = 1'b1;  // high in cycle 10, sampled at edge 11
        for (int i = 0; i < 31; i++) begin
            step();
            bus.sw_req = 1'b0;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL sw_req k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
            if (bus.pad_drive_en === 1'b1) begin
                drive_cnt++;
                if (first_drive < 0) first_drive = m_k;
            end
            if (bus.busy === 1'b0 && busy_fall < 0) busy_fall = m_k;
        end
        total++;
        if (first_drive != 11) begin
            bad++; $display("FAIL sw_drive_start got=%0d exp=11", first_drive);
        end
        total++;
        if (drive_cnt != HOLD) begin
            bad++; $display("FAIL sw_drive_len got=%0d exp=%0d", drive_cnt, HOLD);
        end
        total++;
        if (busy_fall != 32) begin
            bad++; $display("FAIL sw_busy_fall got=%0d exp=32", busy_fall);
        end
        total++;
        if (bus.req_count !== 8'd1) begin
            bad++; $display("FAIL sw_count got=%0d exp=1", bus.req_count);
        end
    endtask

    task automatic test_pb_bounce();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i < 20) bus.pb_n = ((i / 2) % 2) != 0;
            else if (i < 80) bus.pb_n = 1'b0;
            else bus.pb_n = 1'b1;
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL pb_bounce k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
        total++;
        if (bus.req_count !== 8'd1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL pb_single_req count=%0d busy=%b exp count=1 busy=0",
                     bus.req_count, bus.busy);
        end
    endtask

    task automatic test_blocked();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            // Pulses land in DRIVE (i=4) and in the second LOCKOUT cycle.
            bus.sw_req = (i == 1) || (i == 4) || (m_lock >= 0 && m_k == m_lock + 1);
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL blocked k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
        bus.sw_req = 1'b0;
        total++;
        if (bus.req_count !== 8'd1) begin
            bad++; $display("FAIL blocked_count got=%0d exp=1", bus.req_count);
        end
    endtask

    task automatic test_timeout();
        int t0;
        int fault_rise = -1;
        do_reset();
        pad_ok = 1'b0;
        repeat (3) step();
        bus.sw_req = 1'b1;
        step();
        bus.sw_req = 1'b0;
        t0 = m_k;
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL timeout k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
            if (bus.fault === 1'b1 && fault_rise < 0) fault_rise = m_k;
        end
        total++;
        if (fault_rise != t0 + HOLD + TMO) begin
            bad++; $display("FAIL fault_rise got=%0d exp=%0d", fault_rise, t0 + HOLD + TMO);
        end
        pad_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL recover k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
        total++;
        if (bus.fault !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL fault_sticky fault=%b busy=%b exp fault=1 busy=0",
                            bus.fault, bus.busy);
        end
    endtask

    task automatic test_reset_mid_drive();
        do_reset();
        repeat (2) step();
        bus.sw_req = 1'b1;
        step();
        bus.sw_req = 1'b0;
        repeat (4) step();
        total++;
        if (bus.pad_drive_en !== 1'b1) begin
            bad++; $display("FAIL mid_drive_pre got=%b exp=1", bus.pad_drive_en);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        bus.pad_sense = pad_ok;
        #1;
        total++;
        if (obs_vec() !== 11'd0) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", obs_vec(), 11'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.sw_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            bus.sw_req = 1'b0;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL post_reset k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
        total++;
        if (bus.req_count !== 8'd1) begin
            bad++; $display("FAIL post_reset_count got=%0d exp=1", bus.req_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        m_accepts = 0;
        bus.sw_req = 1'b1;
        for (int i = 0; i < 256 * 30 && m_accepts < 256; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL wrap k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
        bus.sw_req = 1'b0;
        total++;
        if (bus.req_count !== 8'h00 || bus.pad_drive_en !== 1'b1) begin
            bad++; $display("FAIL wrap_to_zero count=%h drive=%b exp count=00 drive=1",
                            bus.req_count, bus.pad_drive_en);
        end
        repeat (40) step();
        bus.pb_n = 1'b0;
        for (int i = 0; i < 20 && !m_press_pend; i++) step();
        bus.sw_req = 1'b1;  // same edge as the press event
        step();
        bus.sw_req = 1'b0;
        total++;
        if (bus.req_count !== 8'h01) begin
            bad++; $display("FAIL press_and_sw got=%h exp=01", bus.req_count);
        end
        bus.pb_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL dual_req k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                bus.pb_n = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            bus.sw_req = ($urandom_range(0, 15) == 0);
            if (i % 50 == 0) pad_ok = ($urandom_range(0, 4) != 0);
            step();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random k=%0d got=%h exp=%h", m_k, obs_vec(), exp_vec());
            end
        end
        bus.sw_req = 1'b0;
        bus.pb_n = 1'b1;
    endtask

    initial begin
        bus.sw_req = 1'b0;
        bus.pb_n = 1'b1;
        bus.pad_sense = 1'b1;
        m_accepts = 0;
        test_reset();
        test_sw_req();
        test_pb_bounce();
        test_blocked();
        test_wrap();
        test_random();
        test_timeout();
        test_reset_mid_drive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
